riscv_multiciclo_ctrl: RTL

//  Multicycle control unit for the 8-bit RISC-V datapath. Decodes the fetched instruction into datapath

---
 rtl/riscv_multiciclo_ctrl_pkg.sv | 52 +++++
 rtl/riscv_multiciclo_ctrl_if.sv | 42 ++++
 rtl/riscv_multiciclo_ctrl_ula_decoder.sv | 33 +++
 rtl/riscv_multiciclo_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/riscv_multiciclo_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes, ULA codes.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a. Macro RISCV_CTRL_ILLEGAL_EN adds the TRAP state encoding.
package riscv_multiciclo_ctrl_pkg;

  // FSM state encoding kept as plain constants so older tools and waveform viewers agree on values
  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWRITE = 4'd4;
  localparam state_t S_MEMWB    = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BEQ      = 4'd9;
  localparam state_t S_JAL      = 4'd10;
`ifdef RISCV_CTRL_ILLEGAL_EN
  localparam state_t S_TRAP     = 4'd11;
`endif

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] UOP_ADD   = 2'b00;
  localparam logic [1:0] UOP_SUB   = 2'b01;
  localparam logic [1:0] UOP_FUNCT = 2'b10;

  // Immediate format depends only on the opcode, independent of FSM state
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = 2'b01;
      OP_BEQ:  imm_src_of = 2'b10;
      OP_JAL:  imm_src_of = 2'b11;
      default: imm_src_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/riscv_multiciclo_ctrl_if.sv
// Bundle between control unit (master) and datapath (slave): decode fields in, strobes out.
// Latency: n/a (wires only).
// Backpressure: none. Macro RISCV_CTRL_ILLEGAL_EN adds the Illegal signal.
interface riscv_multiciclo_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ULASrcA;
  logic [1:0] ULASrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ULAControl;
`ifdef RISCV_CTRL_ILLEGAL_EN
  logic       Illegal;
`endif

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ULASrcA, ULASrcB, ImmSrc,
`ifdef RISCV_CTRL_ILLEGAL_EN
    output Illegal,
`endif
    output ULAControl
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ULASrcA, ULASrcB, ImmSrc,
`ifdef RISCV_CTRL_ILLEGAL_EN
    input  Illegal,
`endif
    input  ULAControl
  );
endinterface

// File: rtl/riscv_multiciclo_ctrl_ula_decoder.sv
// Maps ULAOp plus funct fields to the 3-bit ULAControl code.
// Latency: purely combinational.
// Backpressure: none.
module riscv_multiciclo_ctrl_ula_decoder
  import riscv_multiciclo_ctrl_pkg::*;
(
  input  logic [1:0] ula_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ula_control
);

  // op5 separates R-type (register sub allowed) from I-type (addi never subtracts)
  always_comb begin
    ula_control = ULA_ADD;
    case (ula_op)
      UOP_SUB:   ula_control = ULA_SUB;
      UOP_FUNCT: begin
        case (funct3)
          3'b000:  ula_control = (op5 && funct7b5) ? ULA_SUB : ULA_ADD;
          3'b010:  ula_control = ULA_SLT;
          3'b100:  ula_control = ULA_XOR;
          3'b110:  ula_control = ULA_OR;
          3'b111:  ula_control = ULA_AND;
          default: ula_control = ULA_ADD;
        endcase
      end
      default:   ula_control = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multiciclo_ctrl.sv
// Multicycle control FSM for the 8-bit RISC-V datapath; Moore state register, combinational strobes.
// Latency: beq 3, sw/R/I/jal 4, lw 5 cycles; one instruction in flight.
// Backpressure: none, fixed schedule. Macro RISCV_CTRL_ILLEGAL_EN adds TRAP state and Illegal output.
module riscv_multiciclo_ctrl
  import riscv_multiciclo_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  riscv_multiciclo_ctrl_if.master ctrl
);

  state_t     state;
  state_t     state_nxt;
  state_t     cur;
  logic       pc_update;
  logic       branch;
  logic       mem_wr;
  logic       ir_wr;
  logic       reg_wr;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] ula_op;

  // State register; reset from any state aborts the instruction in flight
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state sequencing per instruction class
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
`ifdef RISCV_CTRL_ILLEGAL_EN
          default:      state_nxt = S_TRAP;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_nxt = (ctrl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_nxt = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_nxt = S_ALUWB;
`ifdef RISCV_CTRL_ILLEGAL_EN
      S_TRAP:    state_nxt = S_TRAP;
`endif
      default:   state_nxt = S_FETCH;
    endcase
  end

  // During reset the mux selects look like FETCH so the datapath sees a sane, idle setup
  assign cur = rst ? S_FETCH : state;

  // Per-state strobes and mux selects
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    ula_op     = UOP_ADD;
    case (cur)
      S_FETCH: begin
        ir_wr = 1'b1; src_b = 2'b10; result_src = 2'b10; pc_update = 1'b1;
      end
      S_DECODE:   begin src_a = 2'b01; src_b = 2'b01; end
      S_MEMADR:   begin src_a = 2'b10; src_b = 2'b01; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWRITE: begin adr_src = 1'b1; mem_wr = 1'b1; end
      S_MEMWB:    begin result_src = 2'b01; reg_wr = 1'b1; end
      S_EXECR:    begin src_a = 2'b10; ula_op = UOP_FUNCT; end
      S_EXECI:    begin src_a = 2'b10; src_b = 2'b01; ula_op = UOP_FUNCT; end
      S_ALUWB:    reg_wr = 1'b1;
      S_BEQ:      begin src_a = 2'b10; ula_op = UOP_SUB; branch = 1'b1; end
      S_JAL:      begin src_a = 2'b01; src_b = 2'b10; pc_update = 1'b1; end
      default:    ;
    endcase
  end

  riscv_multiciclo_ctrl_ula_decoder u_ula_dec (
    .ula_op      (ula_op),
    .funct3      (ctrl.funct3),
    .funct7b5    (ctrl.funct7b5),
    .op5         (ctrl.op[5]),
    .ula_control (ctrl.ULAControl)
  );

  // Write enables are gated by reset so no partial write escapes in the reset cycle
  assign ctrl.PCWrite   = ~rst & (pc_update | (branch & ctrl.Zero));
  assign ctrl.MemWrite  = ~rst & mem_wr;
  assign ctrl.IRWrite   = ~rst & ir_wr;
  assign ctrl.RegWrite  = ~rst & reg_wr;
  assign ctrl.AdrSrc    = adr_src;
  assign ctrl.ResultSrc = result_src;
  assign ctrl.ULASrcA   = src_a;
  assign ctrl.ULASrcB   = src_b;
  assign ctrl.ImmSrc    = imm_src_of(ctrl.op);
`ifdef RISCV_CTRL_ILLEGAL_EN
  assign ctrl.Illegal   = ~rst & (state == S_TRAP);
`endif

endmodule
